button_mmio_in: RTL and testbench
=================================

Name: button_mmio_in

Overview:
- Memory-mapped input peripheral for the board push-buttons; the read-side counterpart of the LED output register at 0xf000.
- Synchronises and debounces each raw button input.
- Exposes the debounced levels and sticky press-event flags to the CPU through the 8-bit MMIO read path.
- Sits beside the LED block on the CPU MMIO bus; its `mmio_in` feeds the CPU load-data mux.

Parameters:
- NUM_BUTTONS, 4, number of button inputs, 1..8.
- ACTIVE_LOW, 1, 1 = raw pin reads 0 when pressed; 0 = raw pin reads 1 when pressed.
- DEBOUNCE_CYCLES, 270000, stable cycles required before the debounced level changes (10 ms at 27 MHz); must be >= 1.
- STATE_ADDR, 16'hf001, MMIO address of the debounced-level register.
- EVENT_ADDR, 16'hf002, MMIO address of the press-event register.

Ports:
- clock  input  1  system clock.
- reset  input  1  reset.
- mmio_in_addr  input  16  address of the current CPU load.
- mmio_in_read  input  1  one-cycle strobe; high in the cycle the CPU consumes `mmio_in`.
- mmio_in  output  8  read data for `mmio_in_addr`.
- button  input  NUM_BUTTONS  raw asynchronous button pins.

Behaviour:
- Clocking and reset: single clock domain on the rising edge of `clock`; reset is synchronous and active-high.
- Polarity: pressed = `button[i] ^ ACTIVE_LOW`. Everything after polarity correction uses 1 = pressed.
- Synchroniser: two flip-flop stages per bit. On reset both stages load the released level, so no false press is seen out of reset.
- Debounce, one counter per button:
  - Counter width is `$clog2(DEBOUNCE_CYCLES+1)`.
  - If sync_out[i] == deb[i]: cnt[i] <= 0.
  - Else if cnt[i] == DEBOUNCE_CYCLES-1: deb[i] <= sync_out[i] and cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i] + 1.
  - Any bounce back to the old level restarts the count from 0.
- Latency: a clean level change on the pin first sampled at edge k appears in deb[i] after edge k+1+DEBOUNCE_CYCLES. That is 2 sync cycles plus DEBOUNCE_CYCLES stable cycles, minus 1 for the overlap of the first compare.
- Press event:
  - In a cycle where deb[i] goes 0->1, evt[i] <= 1.
  - Release (1->0) produces no event.
- Read-to-clear:
  - When mmio_in_read=1 and mmio_in_addr==EVENT_ADDR, evt clears every bit that was returned in that cycle's `mmio_in`.
  - A press edge in that same cycle wins: the bit stays 1 and will be seen on the next read.
  - Reads with mmio_in_read=0 never modify state.
  - STATE reads never modify state.
- Read data is a combinational mux of registered state, valid in the same cycle the address is presented:
  - STATE_ADDR: {zero-pad, deb[NUM_BUTTONS-1:0]}.
  - EVENT_ADDR: {zero-pad, evt[NUM_BUTTONS-1:0]}.
  - Any other address: 8'h00.
  - Bits at and above NUM_BUTTONS always read 0.
- Reset values: deb=0, evt=0, cnt=0. `mmio_in` is 8'h00 for every address while reset is held.
- Reset mid-debounce: the in-progress count is discarded. After reset release, a press still held on the pin re-qualifies with full latency and then raises evt.
- Writes: no write behaviour. Stores to STATE_ADDR or EVENT_ADDR are ignored (no write port).

Test Plan:
- Bench parameters: NUM_BUTTONS=4, ACTIVE_LOW=1, DEBOUNCE_CYCLES=4.
- Reset: hold reset 3 cycles with button=4'b1111 -> `mmio_in` reads 8'h00 at 0xf001 and 0xf002, both during reset and for 20 cycles after release.
- Clean press: drive button[0]=0 from edge k, held -> deb[0]=1 after edge k+5 (not earlier); then 0xf001 reads 8'h01 and 0xf002 reads 8'h01.
- Bounce filter: toggle button[1] low/high every 2 cycles for 20 cycles, then hold high -> 0xf001 bit1 stays 0 and 0xf002 stays 8'h00 throughout.
- Read-to-clear:
  - After the press in the clean-press scenario, one read of 0xf002 with mmio_in_read=1 returns 8'h01; the next read returns 8'h00.
  - A 0xf002 read with mmio_in_read=0 returns 8'h01 and does not clear it.
- Simultaneous clear and event: time a button[2] press to qualify in the same cycle as a mmio_in_read of 0xf002 that returns 8'h01 -> the following read returns 8'h04 (bit0 cleared, bit2 retained).
- Decode and release:
  - Address 0xf000 or 0xf003 reads 8'h00.
  - Releasing button[0] clears 0xf001 bit0 after 5 cycles and leaves 0xf002 unchanged.
  - Asserting reset mid-count (cnt=2) and releasing it with the button still held sets deb only after a full 2+4 cycles.

Source files
------------

// File: rtl/button_mmio_in.sv
// Push-button MMIO input block: per-button synchroniser and debouncer,
// with a debounced-level register and a read-to-clear press-event register.
module button_mmio_in #(
  parameter int          NUM_BUTTONS     = 4,
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter int          DEBOUNCE_CYCLES = 270000,
  parameter logic [15:0] STATE_ADDR      = 16'hf001,
  parameter logic [15:0] EVENT_ADDR      = 16'hf002
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [15:0]            mmio_in_addr,
  input  logic                   mmio_in_read,
  output logic [7:0]             mmio_in,
  input  logic [NUM_BUTTONS-1:0] button
);

  localparam int N  = NUM_BUTTONS;
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t CNT_LAST = cnt_t'(DEBOUNCE_CYCLES - 1);

  logic [N-1:0] pol;
  logic [N-1:0] s1_q;
  logic [N-1:0] s2_q;
  logic [N-1:0] deb_q;
  logic [N-1:0] deb_d;
  logic [N-1:0] evt_q;
  logic [N-1:0] evt_d;
  logic [N-1:0] rise;
  cnt_t         cnt_q [N];
  cnt_t         cnt_d [N];
  logic         evt_rd;

  // Polarity-corrected: 1 = pressed from here on
  assign pol = button ^ {N{ACTIVE_LOW}};

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= pol;
      s2_q <= s1_q;
    end
  end

  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          deb_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + cnt_t'(1);
        end
      end
    end
  end

  assign rise   = deb_d & ~deb_q;
  assign evt_rd = mmio_in_read && (mmio_in_addr == EVENT_ADDR);

  // A read returns all of evt, so it clears all of it; a same-cycle press wins
  assign evt_d = (evt_rd ? '0 : evt_q) | rise;

  always_ff @(posedge clock) begin
    if (reset) begin
      deb_q <= '0;
      evt_q <= '0;
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      deb_q <= deb_d;
      evt_q <= evt_d;
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  always_comb begin
    mmio_in = 8'h00;
    if (!reset) begin
      if (mmio_in_addr == STATE_ADDR) begin
        mmio_in[N-1:0] = deb_q;
      end else if (mmio_in_addr == EVENT_ADDR) begin
        mmio_in[N-1:0] = evt_q;
      end
    end
  end

endmodule

// File: tb/tb_button_mmio_in.sv
// Bench for button_mmio_in: directed scenarios plus random stimulus,
// checked against a cycle-level behavioural model of the button rules.
module tb_button_mmio_in;

  localparam int D = 4;
  localparam logic [15:0] SA = 16'hf001;
  localparam logic [15:0] EA = 16'hf002;

  logic        clock;
  logic        reset;
  logic [15:0] mmio_in_addr;
  logic        mmio_in_read;
  logic [7:0]  mmio_in;
  logic [3:0]  button;

  int total;
  int bad;

  logic [3:0] m_p1, m_p2, m_deb, m_evt;
  int         m_run [4];

  button_mmio_in #(
    .NUM_BUTTONS(4),
    .ACTIVE_LOW(1'b1),
    .DEBOUNCE_CYCLES(D),
    .STATE_ADDR(SA),
    .EVENT_ADDR(EA)
  ) dut (
    .clock(clock),
    .reset(reset),
    .mmio_in_addr(mmio_in_addr),
    .mmio_in_read(mmio_in_read),
    .mmio_in(mmio_in),
    .button(button)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [7:0] model_out(input logic rst, input logic [15:0] a);
    logic [7:0] r;
    r = 8'h00;
    if (!rst && a == SA) r = {4'h0, m_deb};
    if (!rst && a == EA) r = {4'h0, m_evt};
    return r;
  endfunction

  // Level must differ from the debounced level for D consecutive cycles
  task automatic model_edge(input logic rst, input logic [3:0] btn,
                            input logic [15:0] a, input logic rd);
    logic [3:0] rise;
    rise = 4'h0;
    if (rst) begin
      m_p1 = 4'h0; m_p2 = 4'h0; m_deb = 4'h0; m_evt = 4'h0;
      for (int i = 0; i < 4; i++) m_run[i] = 0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (m_p2[i] != m_deb[i]) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] == D) begin
            m_deb[i] = m_p2[i];
            m_run[i] = 0;
            if (m_deb[i]) rise[i] = 1'b1;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      if (rd && a == EA) m_evt = 4'h0;
      m_evt = m_evt | rise;
      m_p2 = m_p1;
      m_p1 = ~btn;
    end
  endtask

  task automatic compare(input string tag, input logic [7:0] exp);
    total++;
    assert (mmio_in === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, mmio_in, exp);
    end
  endtask

  // Drive, check at negedge (model + optional constant), then clock
  task automatic cyc(input logic rst, input logic [3:0] btn,
                     input logic [15:0] a, input logic rd,
                     input logic ce, input logic [7:0] cv,
                     input string tag);
    reset = rst;
    button = btn;
    mmio_in_addr = a;
    mmio_in_read = rd;
    @(negedge clock);
    compare({tag, "/model"}, model_out(rst, a));
    if (ce) compare(tag, cv);
    @(posedge clock);
    model_edge(rst, btn, a, rd);
    #1;
  endtask

  initial begin
    total = 0;
    bad = 0;
    m_p1 = 4'h0; m_p2 = 4'h0; m_deb = 4'h0; m_evt = 4'h0;
    for (int i = 0; i < 4; i++) m_run[i] = 0;
    reset = 1'b1;
    button = 4'hf;
    mmio_in_addr = SA;
    mmio_in_read = 1'b0;

    for (int i = 0; i < 3; i++) begin
      cyc(1, 4'hf, (i % 2 == 0) ? SA : EA, 1, 1, 8'h00, "rst_hold");
    end
    for (int i = 0; i < 20; i++) begin
      cyc(0, 4'hf, (i % 2 == 0) ? SA : EA, 0, 1, 8'h00, "post_rst");
    end

    // Clean press on button 0 from edge k
    cyc(0, 4'he, SA, 0, 1, 8'h00, "press0_pre");
    for (int i = 0; i < 5; i++) begin
      cyc(0, 4'he, SA, 0, 1, 8'h00, "press0_early");
    end
    cyc(0, 4'he, SA, 0, 1, 8'h01, "press0_state");
    cyc(0, 4'he, EA, 0, 1, 8'h01, "press0_evt");
    cyc(0, 4'he, EA, 0, 1, 8'h01, "noread_keep");

    // Button 2 qualifies at the edge that ends the clearing read
    cyc(0, 4'ha, EA, 0, 1, 8'h01, "sim_pre");
    for (int i = 0; i < 4; i++) begin
      cyc(0, 4'ha, EA, 0, 1, 8'h01, "sim_wait");
    end
    cyc(0, 4'ha, EA, 1, 1, 8'h01, "sim_clear_rd");
    cyc(0, 4'ha, EA, 1, 1, 8'h04, "sim_retained");
    cyc(0, 4'ha, EA, 0, 1, 8'h00, "rtc_cleared");

    // Bounce on button 1
    for (int i = 0; i < 20; i++) begin
      cyc(0, ((i / 2) % 2 == 0) ? 4'h8 : 4'ha,
          (i % 2 == 0) ? SA : EA, 0, 1,
          (i % 2 == 0) ? 8'h05 : 8'h00, "bounce");
    end
    for (int i = 0; i < 8; i++) begin
      cyc(0, 4'ha, SA, 0, 1, 8'h05, "bounce_hold");
    end

    cyc(0, 4'ha, 16'hf000, 1, 1, 8'h00, "dec_f000");
    cyc(0, 4'ha, 16'hf003, 1, 1, 8'h00, "dec_f003");

    // Release button 0
    cyc(0, 4'hb, SA, 0, 1, 8'h05, "rel_pre");
    for (int i = 0; i < 5; i++) begin
      cyc(0, 4'hb, SA, 0, 1, 8'h05, "rel_early");
    end
    cyc(0, 4'hb, SA, 0, 1, 8'h04, "rel_state");
    cyc(0, 4'hb, EA, 0, 1, 8'h00, "rel_evt");

    // Reset while button 3 is mid-count
    cyc(0, 4'h3, SA, 0, 1, 8'h04, "mid_pre");
    for (int i = 0; i < 3; i++) begin
      cyc(0, 4'h3, SA, 0, 1, 8'h04, "mid_cnt");
    end
    cyc(1, 4'h3, SA, 0, 1, 8'h00, "mid_rst");
    cyc(1, 4'h3, EA, 0, 1, 8'h00, "mid_rst");
    cyc(0, 4'h3, SA, 0, 1, 8'h00, "mid_rel");
    for (int i = 0; i < 5; i++) begin
      cyc(0, 4'h3, SA, 0, 1, 8'h00, "mid_requal_early");
    end
    cyc(0, 4'h3, SA, 0, 1, 8'h0c, "mid_requal");
    cyc(0, 4'h3, EA, 0, 1, 8'h0c, "mid_evt");

    // Random phase against the model only
    begin
      logic [3:0]  b;
      logic [15:0] a;
      logic        r;
      logic        rs;
      b = 4'h3;
      for (int n = 0; n < 600; n++) begin
        if ($urandom_range(5) == 0) b[$urandom_range(3)] ^= 1'b1;
        case ($urandom_range(4))
          0: a = 16'hf000;
          1: a = SA;
          2: a = EA;
          3: a = 16'hf003;
          default: a = 16'($urandom);
        endcase
        r  = 1'($urandom_range(1));
        rs = ($urandom_range(99) == 0);
        cyc(rs, b, a, r, 0, 8'h00, "rand");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
